// File: rtl/keypad_pkg.sv
// Shared types and constants for the matrix keypad scanner.
package keypad_pkg;

    localparam int KEY_W = 4;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        HOLD
    } state_t;

    localparam logic [3:0] COL_PATTERN [4] = '{
        4'b0111,
        4'b1011,
        4'b1101,
        4'b1110
    };

    // {single_row_low, row_idx}; row_idx r means row[3-r] is low
    function automatic logic [2:0] onehot_low_idx(input logic [3:0] row);
        logic [2:0] res;
        res = 3'b000;
        case (row)
            4'b0111: res = 3'b100;
            4'b1011: res = 3'b101;
            4'b1101: res = 3'b110;
            4'b1110: res = 3'b111;
            default: res = 3'b000;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Key report handshake between the keypad scanner and its consumer.
interface keypad_scanner_if;
    import keypad_pkg::*;

    logic [KEY_W-1:0] key_code;
    logic             key_valid;
    logic             key_ack;
    logic             key_overrun;

    modport master (
        output key_code,
        output key_valid,
        output key_overrun,
        input  key_ack
    );

    modport slave (
        input  key_code,
        input  key_valid,
        input  key_overrun,
        output key_ack
    );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs.
module sync_2ff #(
    parameter int               WIDTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner with debounce and valid/ack reporting.
// Auto-repeat while held is enabled by defining KEYPAD_REPEAT_EN.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int DEB_CYC    = 4,
    parameter int PHASE_CYC  = 4,
    parameter int REP_DELAY  = 125,
    parameter int REP_PERIOD = 25
) (
    input  logic              clk_250Hz,
    input  logic              rst_n,
    input  logic [3:0]        ROW,
    output logic [3:0]        COL,
    keypad_scanner_if.master  kbus
);

    // Counters share one width, large enough for the longest limit
    localparam int M1 = (PHASE_CYC > DEB_CYC) ? PHASE_CYC : DEB_CYC;
    localparam int M2 = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
    localparam int CW = $clog2(((M1 > M2) ? M1 : M2) + 1);

    typedef logic [CW-1:0] cnt_t;

    state_t           state, state_n;
    logic [1:0]       col_idx, col_idx_n;
    cnt_t             phase, phase_n;
    cnt_t             cnt, cnt_n, cnt_inc;
    logic [3:0]       lat, lat_n;
    logic [3:0]       col_q, col_n;
    logic [3:0]       rsync;
    logic [2:0]       dec;
    logic             report;
    logic [KEY_W-1:0] report_code;
    logic [KEY_W-1:0] code_q, code_n;
    logic             valid_q, valid_n;
    logic             ovr_q, ovr_n;
`ifdef KEYPAD_REPEAT_EN
    logic             rep_on, rep_on_n;
    logic             rep_first, rep_first_n;
    cnt_t             rep_cnt, rep_cnt_n, rep_inc;
`endif

    sync_2ff #(
        .WIDTH   (4),
        .RST_VAL (4'hf)
    ) u_row_sync (
        .clk   (clk_250Hz),
        .rst_n (rst_n),
        .d     (ROW),
        .q     (rsync)
    );

    assign dec         = onehot_low_idx(lat);
    assign report_code = {dec[1:0], col_idx};
    assign cnt_inc     = cnt + cnt_t'(1);

    always_comb begin
        state_n   = state;
        col_idx_n = col_idx;
        phase_n   = phase;
        cnt_n     = cnt;
        lat_n     = lat;
        report    = 1'b0;
`ifdef KEYPAD_REPEAT_EN
        rep_on_n    = rep_on;
        rep_first_n = rep_first;
        rep_cnt_n   = rep_cnt;
        rep_inc     = rep_cnt + cnt_t'(1);
`endif
        unique case (state)
            SCAN: begin
                if (phase == cnt_t'(PHASE_CYC - 1)) begin
                    phase_n = '0;
                    if (rsync == 4'hf) begin
                        col_idx_n = col_idx + 2'd1;
                    end else begin
                        lat_n   = rsync;
                        cnt_n   = '0;
                        state_n = DEBOUNCE;
                    end
                end else begin
                    phase_n = phase + cnt_t'(1);
                end
            end
            DEBOUNCE: begin
                if (rsync == lat) begin
                    cnt_n = cnt_inc;
                    if (cnt_inc == cnt_t'(DEB_CYC - 1)) begin
                        report  = dec[2];
                        cnt_n   = '0;
                        state_n = HOLD;
`ifdef KEYPAD_REPEAT_EN
                        rep_on_n    = dec[2];
                        rep_first_n = 1'b1;
                        rep_cnt_n   = '0;
`endif
                    end
                end else begin
                    col_idx_n = col_idx + 2'd1;
                    phase_n   = '0;
                    state_n   = SCAN;
                end
            end
            HOLD: begin
                if (rsync == 4'hf) begin
                    cnt_n = cnt_inc;
                    if (cnt_inc == cnt_t'(DEB_CYC)) begin
                        cnt_n     = '0;
                        col_idx_n = col_idx + 2'd1;
                        phase_n   = '0;
                        state_n   = SCAN;
                    end
                end else begin
                    cnt_n = '0;
                end
`ifdef KEYPAD_REPEAT_EN
                if (rep_on) begin
                    if (rsync == lat) begin
                        rep_cnt_n = rep_inc;
                        if (rep_inc == (rep_first ? cnt_t'(REP_DELAY)
                                                  : cnt_t'(REP_PERIOD))) begin
                            report      = 1'b1;
                            rep_cnt_n   = '0;
                            rep_first_n = 1'b0;
                        end
                    end else begin
                        rep_on_n = 1'b0;
                    end
                end
`endif
            end
            default: state_n = SCAN;
        endcase
    end

    always_comb begin
        col_n   = COL_PATTERN[col_idx_n];
        code_n  = code_q;
        valid_n = valid_q;
        ovr_n   = ovr_q;
        if (valid_q && kbus.key_ack) begin
            valid_n = 1'b0;
            ovr_n   = 1'b0;
        end
        // An unacknowledged key is kept; the newer one is dropped
        if (report) begin
            if (valid_q && !kbus.key_ack) begin
                ovr_n = 1'b1;
            end else begin
                code_n  = report_code;
                valid_n = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_250Hz or negedge rst_n) begin
        if (!rst_n) begin
            state   <= SCAN;
            col_idx <= 2'd0;
            phase   <= '0;
            cnt     <= '0;
            lat     <= 4'hf;
            col_q   <= 4'hf;
            code_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rep_on    <= 1'b0;
            rep_first <= 1'b0;
            rep_cnt   <= '0;
`endif
        end else begin
            state   <= state_n;
            col_idx <= col_idx_n;
            phase   <= phase_n;
            cnt     <= cnt_n;
            lat     <= lat_n;
            col_q   <= col_n;
            code_q  <= code_n;
            valid_q <= valid_n;
            ovr_q   <= ovr_n;
`ifdef KEYPAD_REPEAT_EN
            rep_on    <= rep_on_n;
            rep_first <= rep_first_n;
            rep_cnt   <= rep_cnt_n;
`endif
        end
    end

    assign COL              = col_q;
    assign kbus.key_code    = code_q;
    assign kbus.key_valid   = valid_q;
    assign kbus.key_overrun = ovr_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: modelled keypad matrix, queue-based scoreboard.
module tb_keypad_scanner;
    import keypad_pkg::*;

    logic       clk_250Hz = 1'b0;
    logic       rst_n     = 1'b0;
    logic [3:0] ROW;
    logic [3:0] COL;

    keypad_scanner_if kbus();

    keypad_scanner dut (
        .clk_250Hz (clk_250Hz),
        .rst_n     (rst_n),
        .ROW       (ROW),
        .COL       (COL),
        .kbus      (kbus)
    );

    always #2 clk_250Hz = ~clk_250Hz;

    logic [15:0] pressed    = '0;
    logic        bounce_en  = 1'b0;
    logic [3:0]  bounce_row = 4'hf;

    // Key k = 4*r + c connects row r (ROW[3-r]) to column c (COL[3-c])
    always_comb begin
        ROW = 4'hf;
        if (bounce_en) begin
            ROW = bounce_row;
        end else begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    if (pressed[4*r+c] && !COL[3-c])
                        ROW[3-r] = 1'b0;
        end
    end

    int         cyc = 0;
    int         n_tests = 0;
    int         n_fail = 0;
    bit         auto_ack = 1'b1;
    logic [3:0] exp_q[$];
    int         rep_t[$];
    logic [3:0] pat [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};

    always @(posedge clk_250Hz) cyc++;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Monitor: every presented key is popped against the scoreboard and acked
    always @(negedge clk_250Hz) begin
        if (auto_ack && rst_n) begin
            if (kbus.key_ack) begin
                kbus.key_ack = 1'b0;
            end else if (kbus.key_valid) begin
                rep_t.push_back(cyc);
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_report: got code %0h, want none",
                             kbus.key_code);
                end else begin
                    check("key_code", kbus.key_code, exp_q.pop_front());
                end
                kbus.key_ack = 1'b1;
            end
        end
    end

    task automatic hold_key(input int k, input int hold, input int rel);
        pressed[k] = 1'b1;
        repeat (hold) @(negedge clk_250Hz);
        pressed[k] = 1'b0;
        repeat (rel) @(negedge clk_250Hz);
    endtask

    task automatic press_key(input int k, input int hold, input bit bounce);
        int t0;
        logic [3:0] rp;
        rp = 4'hf;
        rp[3 - k/4] = 1'b0;
        rep_t.delete();
        if (bounce) begin
            bounce_en = 1'b1;
            for (int i = 0; i < 10; i++) begin
                bounce_row = i[0] ? 4'hf : rp;
                @(negedge clk_250Hz);
            end
            bounce_en = 1'b0;
        end
        exp_q.push_back(4'(k));
        t0 = cyc;
        hold_key(k, hold, 20);
        check("report_count", rep_t.size(), 1);
        if (!bounce && rep_t.size() > 0)
            check("latency_le_22", (rep_t[0] - t0) <= 22, 1);
    endtask

    initial begin
        logic [3:0] prev;
        int run, idx, trans, i;
        bit started;
        kbus.key_ack = 1'b0;
        repeat (3) @(negedge clk_250Hz);
        check("rst_col", COL, 4'hf);
        check("rst_valid", kbus.key_valid, 0);
        check("rst_code", kbus.key_code, 0);
        check("rst_overrun", kbus.key_overrun, 0);
        rst_n = 1'b1;

        // Idle scan: order and dwell of column strobes
        @(negedge clk_250Hz);
        prev = COL;
        run = 1;
        trans = 0;
        started = 1'b0;
        for (int n = 1; n < 64; n++) begin
            @(negedge clk_250Hz);
            if (COL == prev) begin
                run++;
            end else begin
                if (started) check("col_dwell", run, 4);
                idx = -1;
                for (int p = 0; p < 4; p++) if (pat[p] == prev) idx = p;
                if (idx >= 0) check("col_order", COL, pat[(idx + 1) % 4]);
                started = 1'b1;
                trans++;
                run = 1;
                prev = COL;
            end
        end
        check("idle_transitions", trans >= 14, 1);
        check("idle_valid", kbus.key_valid, 0);

        press_key(9, 40, 1'b0);
        press_key(3, 40, 1'b1);

        // Two rows on one column: no report, scanning resumes
        rep_t.delete();
        pressed[0] = 1'b1;
        pressed[4] = 1'b1;
        repeat (60) @(negedge clk_250Hz);
        pressed = '0;
        repeat (20) @(negedge clk_250Hz);
        check("multikey_reports", rep_t.size(), 0);

        for (int n = 0; n < 12; n++)
            press_key($urandom_range(0, 15), $urandom_range(40, 60),
                      1'($urandom_range(0, 1)));

        // Overrun and ack interplay, consumer driven by hand
        auto_ack = 1'b0;
        repeat (2) @(negedge clk_250Hz);
        hold_key(5, 40, 20);
        check("ovr_first_valid", kbus.key_valid, 1);
        check("ovr_first_code", kbus.key_code, 5);
        hold_key(10, 40, 20);
        check("ovr_code_kept", kbus.key_code, 5);
        check("ovr_flag", kbus.key_overrun, 1);
        kbus.key_ack = 1'b1;
        @(negedge clk_250Hz);
        kbus.key_ack = 1'b0;
        check("ack_valid", kbus.key_valid, 0);
        check("ack_overrun", kbus.key_overrun, 0);
        hold_key(12, 40, 20);
        check("pend_code", kbus.key_code, 12);
        pressed[6] = 1'b1;
        for (i = 0; i < 60 && !dut.report; i++) @(negedge clk_250Hz);
        check("report_wait_timeout", i < 60, 1);
        kbus.key_ack = 1'b1;
        @(negedge clk_250Hz);
        kbus.key_ack = 1'b0;
        check("same_cyc_code", kbus.key_code, 6);
        check("same_cyc_valid", kbus.key_valid, 1);
        check("same_cyc_overrun", kbus.key_overrun, 0);
        repeat (20) @(negedge clk_250Hz);
        pressed[6] = 1'b0;
        repeat (20) @(negedge clk_250Hz);

        // Reset in the middle of debouncing with a key still pending
        pressed[14] = 1'b1;
        for (i = 0; i < 60 && dut.state != DEBOUNCE; i++)
            @(negedge clk_250Hz);
        check("debounce_wait_timeout", i < 60, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_col", COL, 4'hf);
        check("mid_rst_valid", kbus.key_valid, 0);
        check("mid_rst_code", kbus.key_code, 0);
        check("mid_rst_overrun", kbus.key_overrun, 0);
        pressed[14] = 1'b0;
        repeat (2) @(negedge clk_250Hz);
        rst_n = 1'b1;
        @(negedge clk_250Hz);
        check("post_rst_col0", COL, 4'b0111);
        repeat (40) @(negedge clk_250Hz);
        check("post_rst_valid", kbus.key_valid, 0);
        auto_ack = 1'b1;

        press_key($urandom_range(0, 15), 50, 1'b0);

`ifdef KEYPAD_REPEAT_EN
        rep_t.delete();
        repeat (4) exp_q.push_back(4'd7);
        hold_key(7, 200, 30);
        check("repeat_count", rep_t.size(), 4);
        if (rep_t.size() == 4) begin
            check("repeat_first", rep_t[1] - rep_t[0], 125);
            check("repeat_second", rep_t[2] - rep_t[1], 25);
            check("repeat_third", rep_t[3] - rep_t[2], 25);
        end
`endif

        check("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, want finish before time limit");
        $fatal(1);
    end

endmodule
